arm_mainfsm: RTL and testbench

//  Multicycle ARM main control FSM. Sequences FETCH/DECODE/EXECUTE/MEM/WB for data-processing,
//  LDR/STR and B. Emits raw write strobes (NextPC, RegW, MemW, Branch), which the downstream

---
 rtl/arm_mainfsm.sv | 171 +++++++++++++++++
 tb/tb_arm_mainfsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_mainfsm.sv
// Multicycle ARM main control FSM: sequences fetch/decode/execute/memory/writeback and
// emits raw write strobes plus datapath selects. Optional counters: ARM_MAINFSM_PERF_EN.
//
// state   | meaning
// --------+----------------------------------------------
// FETCH   | read instruction at PC, PC <= PC+4
// DECODE  | read registers, compute PC+8
// MEMADR  | compute LDR/STR address
// MEMRD   | read data memory
// MEMWB   | write loaded data to register file
// MEMWR   | write data memory
// EXECR   | ALU op with register operand
// EXECI   | ALU op with immediate operand
// ALUWB   | write ALU result to register file
// BRANCH  | branch target to PC
// UNKNOWN | undefined opcode, flag and refetch
module arm_mainfsm
`ifdef ARM_MAINFSM_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal
`ifdef ARM_MAINFSM_PERF_EN
    ,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrCnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    state_t     state, state_nxt;
    logic       ir_write_d, adr_src_d, alu_op_d, next_pc_d;
    logic       reg_w_d, mem_w_d, branch_d, illegal_d;
    logic [1:0] alu_src_a_d, alu_src_b_d, result_src_d;

    // Only I and S/L of Funct steer the sequence; the ALU function bits go to the decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = S_FETCH;
        ir_write_d   = 1'b0;
        adr_src_d    = 1'b0;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        result_src_d = 2'b00;
        alu_op_d     = 1'b0;
        next_pc_d    = 1'b0;
        reg_w_d      = 1'b0;
        mem_w_d      = 1'b0;
        branch_d     = 1'b0;
        illegal_d    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_d   = 1'b1;
                alu_src_a_d  = 2'b01;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                next_pc_d    = 1'b1;
                state_nxt    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_d  = 2'b01;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                alu_src_b_d = 2'b01;
                state_nxt   = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src_d = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_w_d      = 1'b1;
            end
            S_MEMWR: begin
                adr_src_d = 1'b1;
                mem_w_d   = 1'b1;
            end
            S_EXECR: begin
                alu_op_d  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b_d = 2'b01;
                alu_op_d    = 1'b1;
                state_nxt   = S_ALUWB;
            end
            S_ALUWB: reg_w_d = 1'b1;
            S_BRANCH: begin
                alu_src_b_d  = 2'b01;
                result_src_d = 2'b10;
                branch_d     = 1'b1;
            end
            // UNKNOWN and the spare encodings both flag and return to FETCH
            default: illegal_d = 1'b1;
        endcase
    end

    // Outputs are held inactive for the whole time reset is asserted.
    assign IRWrite   = reset & ir_write_d;
    assign AdrSrc    = reset & adr_src_d;
    assign ALUSrcA   = {2{reset}} & alu_src_a_d;
    assign ALUSrcB   = {2{reset}} & alu_src_b_d;
    assign ResultSrc = {2{reset}} & result_src_d;
    assign ALUOp     = reset & alu_op_d;
    assign NextPC    = reset & next_pc_d;
    assign RegW      = reset & reg_w_d;
    assign MemW      = reset & mem_w_d;
    assign Branch    = reset & branch_d;
    assign Illegal   = reset & illegal_d;

`ifdef ARM_MAINFSM_PERF_EN
    logic instr_done;
    assign instr_done = state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_UNKNOWN};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CycleCnt <= '0;
            InstrCnt <= '0;
        end else begin
            CycleCnt <= CycleCnt + 1'b1;
            if (instr_done) InstrCnt <= InstrCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arm_mainfsm.sv
// Bench for arm_mainfsm: a path model pushes expected states per instruction into a
// queue; each cycle pops one and compares the full output vector against a state table.
module tb_arm_mainfsm;

    typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                  T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_UNKNOWN} tst_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [14:0] obs;
    tst_t       exp_q[$];
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

`ifdef ARM_MAINFSM_PERF_EN
    logic [3:0] cycle_cnt, instr_cnt;
    arm_mainfsm #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .Illegal(Illegal),
        .CycleCnt(cycle_cnt), .InstrCnt(instr_cnt));
`else
    arm_mainfsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .Illegal(Illegal));
`endif

    assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC,
                  RegW, MemW, Branch, Illegal};

    function automatic logic [14:0] exp_outs(input tst_t s);
        logic irw, adr, aop, npc, rw, mw, br, ill;
        logic [1:0] sa, sb, rs;
        {irw, adr, aop, npc, rw, mw, br, ill} = 8'b0;
        {sa, sb, rs} = 6'b0;
        case (s)
            T_FETCH:   begin irw = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; npc = 1; end
            T_DECODE:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            T_MEMADR:  sb = 2'b01;
            T_MEMRD:   adr = 1;
            T_MEMWB:   begin rs = 2'b01; rw = 1; end
            T_MEMWR:   begin adr = 1; mw = 1; end
            T_EXECR:   aop = 1;
            T_EXECI:   begin sb = 2'b01; aop = 1; end
            T_ALUWB:   rw = 1;
            T_BRANCH:  begin sb = 2'b01; rs = 2'b10; br = 1; end
            default:   ill = 1;
        endcase
        return {irw, adr, sa, sb, rs, aop, npc, rw, mw, br, ill};
    endfunction

    task automatic push_path(input logic [1:0] op, input logic [5:0] funct);
        exp_q.push_back(T_FETCH);
        exp_q.push_back(T_DECODE);
        case (op)
            2'b01: begin
                exp_q.push_back(T_MEMADR);
                if (funct[0]) begin exp_q.push_back(T_MEMRD); exp_q.push_back(T_MEMWB); end
                else exp_q.push_back(T_MEMWR);
            end
            2'b00: begin
                exp_q.push_back(funct[5] ? T_EXECI : T_EXECR);
                exp_q.push_back(T_ALUWB);
            end
            2'b10:   exp_q.push_back(T_BRANCH);
            default: exp_q.push_back(T_UNKNOWN);
        endcase
    endtask

    // Entered just after a posedge that left the DUT in FETCH; returns at the negedge of the
    // last state (or, when aborting, just after the posedge at which reset is released).
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                             input bit do_abort, input tst_t abort_st);
        tst_t s;
        push_path(op, funct);
        Op = op;
        Funct = funct;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            @(negedge clk);
            compared++;
            if (obs !== exp_outs(s)) begin
                mismatched++;
                $display("FAIL %s state=%s got=%h exp=%h", name, s.name(), obs, exp_outs(s));
            end
            if (do_abort && s == abort_st) begin
                exp_q.delete();
                reset = 1'b0;
                #1;
                compared++;
                if (obs !== 15'h0) begin
                    mismatched++;
                    $display("FAIL %s_in_reset got=%h exp=%h", name, obs, 15'h0);
                end
                @(posedge clk);
                #1;
                compared++;
                if (obs !== 15'h0) begin
                    mismatched++;
                    $display("FAIL %s_reset_hold got=%h exp=%h", name, obs, 15'h0);
                end
                reset = 1'b1;
            end else if (s == T_DECODE || s == T_MEMADR) begin
                Op = op;
                Funct = funct;
            end else begin
                // inputs outside DECODE/MEMADR must have no effect
                Op = 2'($urandom_range(3));
                Funct = 6'($urandom_range(63));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Op = 2'b00;
        Funct = 6'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (obs !== 15'h0) begin
                mismatched++;
                $display("FAIL reset_outs cycle=%0d got=%h exp=%h", i, obs, 15'h0);
            end
`ifdef ARM_MAINFSM_PERF_EN
            compared++;
            if (cycle_cnt !== 4'd0 || instr_cnt !== 4'd0) begin
                mismatched++;
                $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt);
            end
`endif
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_ldr();
        run_instr("ldr", 2'b01, 6'b011001, 1'b0, T_FETCH);
    endtask

    task automatic test_str();
        run_instr("str", 2'b01, 6'b011000, 1'b0, T_FETCH);
    endtask

    task automatic test_dp();
        run_instr("add_imm", 2'b00, 6'b101000, 1'b0, T_FETCH);
        run_instr("add_reg", 2'b00, 6'b001000, 1'b0, T_FETCH);
    endtask

    task automatic test_branch_undef();
        run_instr("branch", 2'b10, 6'b000000, 1'b0, T_FETCH);
        run_instr("undef", 2'b11, 6'b111111, 1'b0, T_FETCH);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++)
            run_instr("random", 2'($urandom_range(3)), 6'($urandom_range(63)), 1'b0, T_FETCH);
    endtask

    task automatic test_reset_mid();
        run_instr("ldr_abort", 2'b01, 6'b011001, 1'b1, T_MEMRD);
        run_instr("after_abort", 2'b01, 6'b011001, 1'b0, T_FETCH);
    endtask

`ifdef ARM_MAINFSM_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            run_instr("perf_dp", 2'b00, 6'b000100, 1'b0, T_FETCH);
            compared++;
            if (instr_cnt !== 4'(k) || cycle_cnt !== 4'(4 * k + 3)) begin
                mismatched++;
                $display("FAIL perf_cnt k=%0d got=%0d/%0d exp=%0d/%0d", k, instr_cnt,
                         cycle_cnt, 4'(k), 4'(4 * k + 3));
            end
        end
        @(negedge clk);
        compared++;
        if (instr_cnt !== 4'd0 || cycle_cnt !== 4'd0) begin
            mismatched++;
            $display("FAIL perf_wrap got=%0d/%0d exp=0/0", instr_cnt, cycle_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ldr();
        test_str();
        test_dp();
        test_branch_undef();
        test_back_to_back();
        test_reset_mid();
`ifdef ARM_MAINFSM_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
